// File: rtl/alu_top.sv
// Multi-cycle 8-bit ALU with a start/done handshake and a registered 16-bit result.
// Multiply is an iterative shift-add; divide is an iterative restoring divider.
module alu_top (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [7:0]  in_a,
   input  logic [7:0]  in_b,
   output logic        done,
   output logic [15:0] result
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] EXEC     = 3'd1;
   localparam logic [2:0] MUL_ITER = 3'd2;
   localparam logic [2:0] DIV_ITER = 3'd3;
   localparam logic [2:0] FINISH   = 3'd4;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;

   logic [2:0]  state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [7:0]  a_q, a_d;
   logic [7:0]  b_q, b_d;
   logic [15:0] accum_q, accum_d;
   logic [15:0] mcand_q, mcand_d;
   logic [7:0]  mplier_q, mplier_d;
   logic [7:0]  rem_q, rem_d;
   logic [7:0]  quot_q, quot_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        done_q, done_d;
   logic [15:0] result_q, result_d;

   logic [8:0]  addSum;
   logic [15:0] execResult;
   logic [8:0]  divShift;
   logic        divFits;
   logic [7:0]  divDiff;

   assign addSum = {1'b0, a_q} + {1'b0, b_q};

   // quot_q doubles as the dividend shift register; its MSB feeds the remainder
   // while quotient bits enter at the LSB. The true difference always fits in 8 bits.
   assign divShift = {rem_q, quot_q[7]};
   assign divFits  = (divShift >= {1'b0, b_q});
   assign divDiff  = divShift[7:0] - b_q;

   // Single-cycle operations; DIV only lands here when the divisor is zero.
   always_comb begin
      execResult = 16'h0000;
      case (op_q)
         OP_ADD:  execResult = {7'b0, addSum};
         OP_SUB:  execResult = {8'h00, a_q} - {8'h00, b_q};
         OP_DIV:  execResult = 16'hFFFF;
         OP_AND:  execResult = {8'h00, a_q & b_q};
         OP_OR:   execResult = {8'h00, a_q | b_q};
         OP_XOR:  execResult = {8'h00, a_q ^ b_q};
         default: execResult = 16'h0000;
      endcase
   end

   // Controller: acceptance in IDLE, iteration phases, and completion.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      accum_d  = accum_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      rem_d    = rem_q;
      quot_d   = quot_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d     = op;
               a_d      = in_a;
               b_d      = in_b;
               done_d   = 1'b0;
               cnt_d    = 3'd0;
               accum_d  = 16'h0000;
               mcand_d  = {8'h00, in_a};
               mplier_d = in_b;
               rem_d    = 8'h00;
               quot_d   = in_a;
               if (op == OP_MUL) begin
                  state_d = MUL_ITER;
               end else if ((op == OP_DIV) && (in_b != 8'h00)) begin
                  state_d = DIV_ITER;
               end else begin
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            result_d = execResult;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         MUL_ITER: begin
            if (mplier_q[0]) begin
               accum_d = accum_q + mcand_q;
            end
            mcand_d  = {mcand_q[14:0], 1'b0};
            mplier_d = {1'b0, mplier_q[7:1]};
            cnt_d    = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = FINISH;
            end
         end
         DIV_ITER: begin
            if (divFits) begin
               rem_d  = divDiff;
               quot_d = {quot_q[6:0], 1'b1};
            end else begin
               rem_d  = divShift[7:0];
               quot_d = {quot_q[6:0], 1'b0};
            end
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            result_d = (op_q == OP_MUL) ? accum_q : {rem_q, quot_q};
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // All state, including the outputs, clears immediately on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= 3'd0;
         a_q      <= 8'h00;
         b_q      <= 8'h00;
         accum_q  <= 16'h0000;
         mcand_q  <= 16'h0000;
         mplier_q <= 8'h00;
         rem_q    <= 8'h00;
         quot_q   <= 8'h00;
         cnt_q    <= 3'd0;
         done_q   <= 1'b0;
         result_q <= 16'h0000;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         accum_q  <= accum_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         rem_q    <= rem_d;
         quot_q   <= quot_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_alu_top.sv
// Scoreboard bench for alu_top: the driver queues hand-computed results and
// latencies, and a monitor checks them on every rising edge of done.
module tb_alu_top;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        done;
   logic [15:0] result;

   typedef struct {
      logic [15:0] res;
      int          lat;
      int          acceptCycle;
      string       name;
   } expT;

   expT         sbQ[$];
   int          errors = 0;
   int          checks = 0;
   int          cycle = 0;
   logic        donePrev = 1'b0;
   logic [15:0] lastResult = 16'h0000;

   alu_top dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .in_a   (in_a),
      .in_b   (in_b),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: pop one expectation per completion and compare result and latency.
   always @(negedge clk) begin
      if (reset) begin
         donePrev = 1'b0;
      end else begin
         if (done && !donePrev) begin
            if (sbQ.size() == 0) begin
               checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
               expT e;
               e = sbQ.pop_front();
               checkOutput({e.name, "_result"}, {16'h0, result}, {16'h0, e.res});
               checkOutput({e.name, "_latency"}, cycle - e.acceptCycle, e.lat);
            end
         end
         donePrev = done;
      end
   end

   task automatic pushExp(input string name, input logic [15:0] res, input int lat);
      expT e;
      e.res = res;
      e.lat = lat;
      e.acceptCycle = cycle;
      e.name = name;
      sbQ.push_back(e);
   endtask

   task automatic waitDone(input string name);
      for (int k = 0; k < 20 && !done; k++) @(negedge clk);
      checkOutput({name, "_done_seen"}, {31'h0, done}, 32'd1);
   endtask

   task automatic applyStimulus(input string name, input logic [2:0] opc, input logic [7:0] a,
                                input logic [7:0] b, input logic [15:0] expRes, input int expLat,
                                input bit pulseDuring);
      @(negedge clk);
      start = 1'b1;
      op    = opc;
      in_a  = a;
      in_b  = b;
      @(negedge clk);
      pushExp(name, expRes, expLat);
      checkOutput({name, "_accept_done"}, {31'h0, done}, 32'd0);
      checkOutput({name, "_accept_hold"}, {16'h0, result}, {16'h0, lastResult});
      start = 1'b0;
      op    = opc ^ 3'b011;
      in_a  = ~a;
      in_b  = ~b;
      if (pulseDuring) begin
         @(negedge clk);
         @(negedge clk);
         start = 1'b1;
         op    = 3'b000;
         @(negedge clk);
         start = 1'b0;
      end
      waitDone(name);
      lastResult = expRes;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = 3'b000;
      in_a  = 8'h00;
      in_b  = 8'h00;
      repeat (2) @(negedge clk);
      checkOutput("reset_done", {31'h0, done}, 32'd0);
      checkOutput("reset_result", {16'h0, result}, 32'h0);
      reset = 1'b0;

      applyStimulus("add_25_17",   3'b000, 8'd25,  8'd17,  16'h002A, 1, 1'b0);
      applyStimulus("add_200_100", 3'b000, 8'd200, 8'd100, 16'h012C, 1, 1'b0);
      applyStimulus("add_255_255", 3'b000, 8'd255, 8'd255, 16'h01FE, 1, 1'b0);
      applyStimulus("sub_42_15",   3'b001, 8'd42,  8'd15,  16'h001B, 1, 1'b0);
      applyStimulus("sub_5_10",    3'b001, 8'd5,   8'd10,  16'hFFFB, 1, 1'b0);
      applyStimulus("mul_6_9",     3'b010, 8'd6,   8'd9,   16'h0036, 9, 1'b1);
      applyStimulus("mul_255_255", 3'b010, 8'd255, 8'd255, 16'hFE01, 9, 1'b0);
      applyStimulus("div_100_4",   3'b011, 8'd100, 8'd4,   16'h0019, 9, 1'b0);
      applyStimulus("div_7_2",     3'b011, 8'd7,   8'd2,   16'h0103, 9, 1'b0);
      applyStimulus("div_10_0",    3'b011, 8'd10,  8'd0,   16'hFFFF, 1, 1'b0);
      applyStimulus("op_111",      3'b111, 8'd10,  8'd3,   16'h0000, 1, 1'b0);
      applyStimulus("and_aa_cc",   3'b100, 8'hAA,  8'hCC,  16'h0088, 1, 1'b0);
      applyStimulus("or_aa_cc",    3'b101, 8'hAA,  8'hCC,  16'h00EE, 1, 1'b0);

      // done and result must hold while idle.
      repeat (3) @(negedge clk);
      checkOutput("idle_done_held", {31'h0, done}, 32'd1);
      checkOutput("idle_result_held", {16'h0, result}, 32'h00EE);

      applyStimulus("xor_aa_cc",   3'b110, 8'hAA,  8'hCC,  16'h0066, 1, 1'b0);

      // start held high re-triggers on the first IDLE edge after completion.
      @(negedge clk);
      start = 1'b1;
      op    = 3'b000;
      in_a  = 8'd3;
      in_b  = 8'd4;
      @(negedge clk);
      pushExp("held_first", 16'h0007, 1);
      @(negedge clk);
      @(negedge clk);
      pushExp("held_second", 16'h0007, 1);
      checkOutput("held_reaccept_done", {31'h0, done}, 32'd0);
      start = 1'b0;
      waitDone("held_second");
      lastResult = 16'h0007;

      // Asynchronous reset in the middle of a multiply.
      @(negedge clk);
      start = 1'b1;
      op    = 3'b010;
      in_a  = 8'd200;
      in_b  = 8'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checkOutput("midreset_done", {31'h0, done}, 32'd0);
      checkOutput("midreset_result", {16'h0, result}, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      lastResult = 16'h0000;
      applyStimulus("mul_after_reset", 3'b010, 8'd12, 8'd11, 16'h0084, 9, 1'b0);
      applyStimulus("div_255_255",     3'b011, 8'd255, 8'd255, 16'h0001, 9, 1'b0);

      repeat (2) @(negedge clk);
      checkOutput("scoreboard_empty", sbQ.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/alu_top.md
Name: alu_top

Overview:
- Multi-cycle 8-bit ALU with a start/done handshake and a 16-bit result.
- Supports add, subtract, multiply, divide, AND, OR and XOR, selected by a 3-bit opcode.
- Multiply is an iterative shift-add; divide is an iterative restoring divider. All other operations complete in one execute cycle.
- Sits behind a simple controller that pulses start and waits for done.

Parameters:
- none. Data width is fixed at 8-bit operands and a 16-bit result.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 reserved
- in_a  input  8  operand A, unsigned
- in_b  input  8  operand B, unsigned
- done  output  1  result valid; level signal, held until the next accepted start
- result  output  16  operation result, registered

Behaviour:
- One clock domain, clk. reset is asynchronous and active-high.
- Reset values: done=0, result=0x0000, state=IDLE, all internal registers 0.
- Reset mid-operation aborts the operation immediately, with the same values as above.
- States: IDLE, EXEC, MUL_ITER, DIV_ITER, FINISH.
- Acceptance, at edge E0 in IDLE with start=1:
  - latch op, in_a and in_b; clear done; result holds its old value.
  - Inputs changing after E0 have no effect on the operation in flight.
- start while not in IDLE is ignored. No queuing.
- start held high continuously re-triggers on the first IDLE edge after each completion.
- Next state after acceptance:
  - ADD/SUB/AND/OR/XOR/111, and DIV with in_b=0 → EXEC.
  - MUL → MUL_ITER.
  - DIV with in_b≠0 → DIV_ITER.
- EXEC, at edge E1: write result, set done=1, go to IDLE. Latency is 1 cycle after acceptance.
- MUL_ITER:
  - 8 iterations at E1..E8, one multiplier bit per cycle, LSB first.
  - If the bit is 1, add the shifted multiplicand into a 16-bit accumulator.
  - A 3-bit counter ends the phase after the 8th iteration → FINISH.
- DIV_ITER:
  - Restoring division, 8 iterations at E1..E8, MSB first.
  - Shift the remainder left and bring in the next dividend bit; trial-subtract the divisor.
  - If the trial result is non-negative, keep it and set the quotient bit; otherwise restore.
  - → FINISH.
- FINISH, at edge E9: write result, set done=1, go to IDLE. MUL/DIV latency is 9 cycles after acceptance.
- Result formats:
  - ADD: zero-extended 9-bit sum {7'b0, carry, sum}; 255+255 = 0x01FE.
  - SUB: 16-bit two's-complement of A−B on zero-extended operands; 5−10 = 0xFFFB.
  - MUL: full unsigned 16-bit product; 255×255 = 0xFE01.
  - DIV: {remainder[7:0], quotient[7:0]}; 7/2 = 0x0103.
  - DIV by zero: result=0xFFFF via EXEC at 1-cycle latency; done asserted normally.
  - AND/OR/XOR: bitwise on 8 bits, zero-extended to 16.
  - op=111: result=0x0000, done asserted normally.
- result is stable while done=1 and changes only at completion or reset.
- Back-to-back operations: a start accepted on the same edge that done is cleared is allowed. Minimum spacing is completion edge + 1.

Test Plan:
- ADD 25+17: start pulse of 1 cycle → done at E1, result=42 (0x002A). Also 200+100 → 0x012C.
- SUB 42−15 → 27 (0x001B). Also 5−10 → 0xFFFB.
- MUL 6×9 → done exactly at E9, result=54 (0x0036). Also 255×255 → 0xFE01. start pulses during MUL_ITER are ignored.
- DIV 100/4 → 0x0019 at E9. 7/2 → 0x0103. 10/0 → 0xFFFF with done at E1.
- A=0xAA, B=0xCC → AND 0x0088, OR 0x00EE, XOR 0x0066. done stays high until the next start, then drops at the acceptance edge.
- reset asserted asynchronously mid-MUL → done=0 and result=0 immediately. The next start completes correctly.
